div32x32_seq: RTL and testbench

Sequential unsigned 32-bit by 32-bit divider, the division counterpart of the team's 32x32 multiplier in the arithmetic simulation block set.
- Restoring radix-2 algorithm: one quotient bit per clock.
- Start/busy/done handshake.
- Early exit for trivial operands (divisor zero, dividend < divisor), analogous to the multiplier's MSW-is-zero shortcut.

---
 rtl/div32x32_seq.sv | 159 +++++++++++++++
 tb/tb_div32x32_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div32x32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div32x32_seq
//  Purpose  : Sequential unsigned WIDTH/WIDTH restoring divider, one quotient
//             bit per clock, with start/busy/done handshake and a one-cycle
//             shortcut for a zero divisor or a dividend below the divisor.
//  Revision : 1.0  initial release
// ============================================================================
module div32x32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Partial remainder, shifting dividend/quotient, latched divisor, step count
  logic [WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_b;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   r_quotient;
  logic [WIDTH-1:0]   r_remainder;
  logic               r_div_by_zero;

  logic [WIDTH:0]     w_t;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_p_nxt;
  logic [WIDTH-1:0]   w_q_nxt;
  logic               w_last;
  logic               w_b_zero;
  logic               w_a_lt_b;

  // One restoring step: shift in the next dividend bit, try to subtract.
  // The trial value is compared at WIDTH+1 bits so a carry out of the shift
  // is never lost. When the subtract succeeds the true difference is below
  // the divisor, so the low WIDTH bits of a WIDTH-bit subtract are exact.
  always_comb begin
    w_t      = {r_p, r_q[WIDTH-1]};
    w_ge     = (w_t >= {1'b0, r_b});
    w_diff   = w_t[WIDTH-1:0] - r_b;
    w_p_nxt  = w_ge ? w_diff : w_t[WIDTH-1:0];
    w_q_nxt  = {r_q[WIDTH-2:0], w_ge};
    w_last   = (r_cnt == CNT_W'(1));
    w_b_zero = (b == '0);
    w_a_lt_b = (a < b);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: trivial operands go straight to DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_b_zero || w_a_lt_b) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration, and result registers. Results are
  // written only on entry to DONE so no intermediate value is ever visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p           <= '0;
      r_q           <= '0;
      r_b           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_b <= b;
            r_q <= a;
            r_p <= '0;
            if (w_b_zero) begin
              r_quotient    <= '1;
              r_remainder   <= a;
              r_div_by_zero <= 1'b1;
            end else if (w_a_lt_b) begin
              r_quotient    <= '0;
              r_remainder   <= a;
              r_div_by_zero <= 1'b0;
            end else begin
              r_cnt <= CNT_W'(WIDTH);
            end
          end
        end
        S_RUN: begin
          r_p   <= w_p_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_quotient    <= w_q_nxt;
            r_remainder   <= w_p_nxt;
            r_div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_div32x32_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div32x32_seq
//  Purpose  : Self-checking bench for div32x32_seq. A driver issues divisions
//             and queues the expected result and accept time; a monitor pops
//             and checks on every done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div32x32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          edges;
    longint      t0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  div32x32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference model: result and number of edges from accept to entering DONE
  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input longint t0);
    exp_t e;
    if (bv == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = av; e.dz = 1'b1; e.edges = 0;
    end else begin
      e.q = av / bv; e.r = av % bv; e.dz = 1'b0;
      e.edges = (av < bv) ? 0 : 32;
    end
    e.t0 = t0;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 q=0x%08h expected no done", quotient);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("latency_edges", 32'(($time - e.t0 - 5) / 10), 32'(e.edges));
        chk("busy_in_done", {31'd0, busy}, 32'd1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
    end
  endtask

  // Issue one operation; optionally queue its expectation and scramble a/b
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit push);
    longint t0;
    wait_idle();
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    t0 = $time;
    if (push) sb.push_back(model(av, bv, t0));
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got done=%0b expected 1", done);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_quotient"}, quotient, 32'd0);
    chk({tag, "_remainder"}, remainder, 32'd0);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    longint      t0;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("reset_state");

    // Full path with ignored starts during RUN and in the DONE cycle
    issue(32'd100, 32'd7, 1'b1);
    @(negedge clk);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    start = 1'b0;
    drain();

    // Fast paths and extremes
    issue(32'd5, 32'd9, 1'b1);
    issue(32'd0, 32'd0, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 1'b1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(32'h8000_0000, 32'h8000_0001, 1'b1);
    issue(32'd12345678, 32'd0, 1'b1);
    issue(32'hDEAD_BEEF, 32'd16, 1'b1);
    drain();

    // start held high: second acceptance two edges after DONE is entered
    wait_idle();
    a = 32'd20; b = 32'd3; start = 1'b1;
    @(posedge clk);
    t0 = $time;
    sb.push_back(model(32'd20, 32'd3, t0));
    sb.push_back(model(32'd20, 32'd3, t0 + 340));
    #341;
    start = 1'b0;
    a = $urandom; b = $urandom;
    drain();

    // Reset in the middle of a run aborts with no done pulse
    issue(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_zero("abort");
    issue(32'd1000, 32'd3, 1'b1);
    drain();

    // Reset and start on the same edge: start is dropped
    wait_idle();
    reset = 1'b1; start = 1'b1; a = 32'd50; b = 32'd5;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    // Mixed operand classes
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = 32'd0; end
        1: begin rb = $urandom; if (rb == 32'd0) rb = 32'd1; ra = $urandom % rb; end
        2: begin ra = $urandom; rb = 32'($urandom_range(1, 255)); end
        default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
      endcase
      issue(ra, rb, 1'b1);
    end
    drain();

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
